// File: rtl/serial_word_shifter.sv
// Parallel-to-serial shifter feeding a serial detector: a WIDTH-bit word is accepted
// through load/ready and emitted one bit per clock, followed by GAP forced-zero cycles.
module serial_word_shifter #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             done,
    output logic             busy
);

    localparam int            CNT_MAX    = (WIDTH > GAP) ? WIDTH : GAP;
    localparam int            CW         = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);
    localparam logic [CW-1:0] LAST_GAP   = (GAP > 0) ? CW'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  shift_q;
    logic [CW-1:0]     count_q;

    logic              accept;
    logic              first_bit;
    logic              next_bit;
    logic [WIDTH-1:0]  load_shift_d;
    logic [WIDTH-1:0]  shift_d;

    // Decoded from state/count only, so load never reaches ready combinationally.
    assign ready = (state_q == S_IDLE) ||
                   ((GAP == 0) && (state_q == S_SHIFT) && (count_q == LAST_BIT));
    assign accept = load & ready;

    // The shift register holds only the bits not yet presented on x_out.
    assign first_bit    = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
    assign load_shift_d = MSB_FIRST ? (data_in << 1)   : (data_in >> 1);
    assign next_bit     = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign shift_d      = MSB_FIRST ? (shift_q << 1)   : (shift_q >> 1);

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            count_q   <= '0;
            x_out     <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            state_q   <= S_SHIFT;
            shift_q   <= load_shift_d;
            count_q   <= '0;
            x_out     <= first_bit;
            bit_valid <= 1'b1;
            done      <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    x_out     <= 1'b0;
                    bit_valid <= 1'b0;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                S_SHIFT: begin
                    if (count_q == LAST_BIT) begin
                        count_q   <= '0;
                        x_out     <= 1'b0;
                        bit_valid <= 1'b0;
                        done      <= 1'b0;
                        if (GAP > 0) begin
                            state_q <= S_GAP;
                            busy    <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        count_q <= count_q + 1'b1;
                        shift_q <= shift_d;
                        x_out   <= next_bit;
                        done    <= (count_q == PENULT_BIT);
                    end
                end
                S_GAP: begin
                    if (count_q == LAST_GAP) begin
                        state_q <= S_IDLE;
                        count_q <= '0;
                        busy    <= 1'b0;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_shifter.sv
// Directed bench for serial_word_shifter: three instances cover MSB-first with gap,
// LSB-first with gap, and gapless back-to-back streaming.
module tb_serial_word_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_a, load_b, load_c;
    logic [7:0] data_a, data_b, data_c;
    logic       ready_a, x_a, bv_a, done_a, busy_a;
    logic       ready_b, x_b, bv_b, done_b, busy_b;
    logic       ready_c, x_c, bv_c, done_c, busy_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(2)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .load(load_a), .ready(ready_a),
        .x_out(x_a), .bit_valid(bv_a), .done(done_a), .busy(busy_a)
    );

    serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .load(load_b), .ready(ready_b),
        .x_out(x_b), .bit_valid(bv_b), .done(done_b), .busy(busy_b)
    );

    serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0)) dut_c (
        .clk(clk), .rst(rst), .data_in(data_c), .load(load_c), .ready(ready_c),
        .x_out(x_c), .bit_valid(bv_c), .done(done_c), .busy(busy_c)
    );

    // Observed outputs packed as {x_out, bit_valid, done, busy, ready}.
    function automatic logic [4:0] obs(input int sel);
        case (sel)
            0:       return {x_a, bv_a, done_a, busy_a, ready_a};
            1:       return {x_b, bv_b, done_b, busy_b, ready_b};
            default: return {x_c, bv_c, done_c, busy_c, ready_c};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        for (int s = 0; s < 3; s++) begin
            got = obs(s);
            if (got !== 5'b00001) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %b expected %b (x,valid,done,busy,ready)", s, got, 5'b00001);
            end
            checks++;
        end
        @(negedge clk);
        rst = 1'b1;
        step();
        got = obs(0);
        if (got !== 5'b00001) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", got, 5'b00001);
        end
        checks++;
    endtask

    task automatic test_msb_gap();
        logic [7:0] d = 8'b1011_0001;
        logic [4:0] exp, got;
        data_a = d;
        load_a = 1'b1;
        step();
        load_a = 1'b0;
        data_a = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp = {d[7-i], 1'b1, (i == 7), 1'b1, 1'b0};
            got = obs(0);
            if (got !== exp) begin
                errors++;
                $display("FAIL msb_gap bit%0d: got %b expected %b", i + 1, got, exp);
            end
            checks++;
            step();
        end
        for (int g = 0; g < 2; g++) begin
            got = obs(0);
            if (got !== 5'b00010) begin
                errors++;
                $display("FAIL msb_gap gap%0d: got %b expected %b", g, got, 5'b00010);
            end
            checks++;
            step();
        end
        got = obs(0);
        if (got !== 5'b00001) begin
            errors++;
            $display("FAIL msb_gap idle: got %b expected %b", got, 5'b00001);
        end
        checks++;
    endtask

    task automatic test_lsb_first();
        logic [7:0] d = 8'hA5;
        logic [4:0] exp, got;
        data_b = d;
        load_b = 1'b1;
        step();
        load_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {d[i], 1'b1, (i == 7), 1'b1, 1'b0};
            got = obs(1);
            if (got !== exp) begin
                errors++;
                $display("FAIL lsb_first bit%0d: got %b expected %b", i + 1, got, exp);
            end
            checks++;
            step();
        end
        step();
        step();
        got = obs(1);
        if (got !== 5'b00001) begin
            errors++;
            $display("FAIL lsb_first idle: got %b expected %b", got, 5'b00001);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0 = 8'hA5;
        logic [7:0] d1 = 8'h3C;
        logic       b, last;
        logic [4:0] exp, got;
        data_c = d0;
        load_c = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            b    = (i < 8) ? d0[7-i] : d1[15-i];
            last = (i == 7) || (i == 15);
            exp  = {b, 1'b1, last, 1'b1, last};
            got  = obs(2);
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back bit%0d: got %b expected %b", i + 1, got, exp);
            end
            checks++;
            if (i == 7) data_c = d1;
            if (i == 15) load_c = 1'b0;
            step();
        end
        for (int k = 0; k < 2; k++) begin
            got = obs(2);
            if (got !== 5'b00001) begin
                errors++;
                $display("FAIL back_to_back idle%0d: got %b expected %b", k, got, 5'b00001);
            end
            checks++;
            step();
        end
    endtask

    task automatic test_load_ignored();
        logic [4:0] exp, got;
        data_a = 8'h00;
        load_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b0, 1'b1, (i == 7), 1'b1, 1'b0};
            got = obs(0);
            if (got !== exp) begin
                errors++;
                $display("FAIL load_ignored bit%0d: got %b expected %b", i + 1, got, exp);
            end
            checks++;
            if (i >= 1 && i <= 4) begin
                load_a = 1'b1;
                data_a = 8'hFF;
            end else begin
                load_a = 1'b0;
            end
            step();
        end
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            got = obs(0);
            if (got !== 5'b00001) begin
                errors++;
                $display("FAIL load_ignored idle%0d: got %b expected %b", k, got, 5'b00001);
            end
            checks++;
            step();
        end
    endtask

    task automatic test_reset_mid_word();
        logic [4:0] exp, got;
        data_a = 8'hFF;
        load_a = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            got = obs(0);
            if (got !== 5'b11010) begin
                errors++;
                $display("FAIL mid_reset pre bit%0d: got %b expected %b", i + 1, got, 5'b11010);
            end
            checks++;
            if (i < 2) step();
        end
        #3;
        rst = 1'b0;
        #1;
        got = obs(0);
        if (got !== 5'b00001) begin
            errors++;
            $display("FAIL mid_reset async: got %b expected %b", got, 5'b00001);
        end
        checks++;
        step();
        got = obs(0);
        if (got !== 5'b00001) begin
            errors++;
            $display("FAIL mid_reset held: got %b expected %b", got, 5'b00001);
        end
        checks++;
        load_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            got = obs(0);
            if (got !== 5'b00001) begin
                errors++;
                $display("FAIL mid_reset after_release%0d: got %b expected %b", k, got, 5'b00001);
            end
            checks++;
        end
        load_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, 1'b1, (i == 7), 1'b1, 1'b0};
            got = obs(0);
            if (got !== exp) begin
                errors++;
                $display("FAIL mid_reset fresh bit%0d: got %b expected %b", i + 1, got, exp);
            end
            checks++;
            step();
        end
        step();
        step();
        got = obs(0);
        if (got !== 5'b00001) begin
            errors++;
            $display("FAIL mid_reset fresh idle: got %b expected %b", got, 5'b00001);
        end
        checks++;
    endtask

    initial begin
        rst    = 1'b0;
        load_a = 1'b0;
        load_b = 1'b0;
        load_c = 1'b0;
        data_a = 8'h00;
        data_b = 8'h00;
        data_c = 8'h00;
        #2;
        test_reset();
        test_msb_gap();
        test_lsb_first();
        test_back_to_back();
        test_load_ignored();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
